// File: rtl/r_order_release.sv
// ---------------------------------------------------------------------------
// r_order_release
//
// Purpose:
//   Reorders R-channel bursts back into AR issue order. Every issued read
//   pushes its (internal UID, original ARID) pair into an in-order queue.
//   Beats are requested from the per-UID response memory for the head UID
//   only. They are forwarded to the master R channel with the original ID
//   restored, and the head entry retires on the RLAST handshake.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ord_push_*                 enqueue of a newly issued read (valid/ready)
//   free_req, uid_to_free      drain request for the head UID
//   free_ack                   response memory has a beat for uid_to_free
//   rm_*                       beat from response memory, rm_ready = pop strobe
//   m_*                        master R channel
//   order_count                occupied queue entries
//   busy                       FSM is in STREAM
//   err_order                  sticky protocol error flag
//
// Optional feature:
//   R_ORDER_CHECK_EN - when defined, err_order flags a beat whose UID is not
//   the head UID, or a free_ack that disagrees with rm_valid, while in
//   STREAM. When undefined, err_order is tied to 0 and no compare logic
//   is built.
// ---------------------------------------------------------------------------
module r_order_release #(
    parameter int NUM_UIDS      = 16,
    parameter int ID_WIDTH      = 4,
    parameter int ORIG_ID_WIDTH = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int RESP_WIDTH    = 2,
    parameter int ORDER_DEPTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ord_push_valid,
    input  logic [ID_WIDTH-1:0]                ord_push_uid,
    input  logic [ORIG_ID_WIDTH-1:0]           ord_push_orig_id,
    output logic                               ord_push_ready,
    output logic                               free_req,
    output logic [ID_WIDTH-1:0]                uid_to_free,
    input  logic                               free_ack,
    input  logic                               rm_valid,
    input  logic [ID_WIDTH-1:0]                rm_id,
    input  logic [DATA_WIDTH-1:0]              rm_data,
    input  logic [RESP_WIDTH-1:0]              rm_resp,
    input  logic                               rm_last,
    output logic                               rm_ready,
    output logic                               m_valid,
    output logic [ORIG_ID_WIDTH-1:0]           m_id,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic [RESP_WIDTH-1:0]              m_resp,
    output logic                               m_last,
    input  logic                               m_ready,
    output logic [$clog2(ORDER_DEPTH+1)-1:0]   order_count,
    output logic                               busy,
    output logic                               err_order
);

    localparam int PW = $clog2(ORDER_DEPTH);
    localparam int CW = $clog2(ORDER_DEPTH + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                   state_reg;
    logic [PW-1:0]            rd_ptr_reg;
    logic [PW-1:0]            wr_ptr_reg;
    logic [CW-1:0]            count_reg;
    logic [ID_WIDTH-1:0]      last_uid_reg;

    logic [ID_WIDTH-1:0]      uid_mem  [ORDER_DEPTH];
    logic [ORIG_ID_WIDTH-1:0] orig_mem [ORDER_DEPTH];

    logic                     streaming;
    logic                     push_fire;
    logic                     retire;
    logic [ID_WIDTH-1:0]      head_uid;
    logic [ORIG_ID_WIDTH-1:0] head_orig;

    // NUM_UIDS is descriptive only; the UID space is defined by ID_WIDTH.
    logic unused_param;
    assign unused_param = (NUM_UIDS > 0);

    // -----------------------------------------------------------------------
    // Queue head and handshake decode
    // -----------------------------------------------------------------------
    assign head_uid  = uid_mem[rd_ptr_reg];
    assign head_orig = orig_mem[rd_ptr_reg];
    assign streaming = (state_reg == STREAM);

    // Readiness depends only on the registered count, so a same-cycle pop
    // never frees space for a push. Held low while reset is asserted.
    assign ord_push_ready = rst_n & (count_reg != CW'(ORDER_DEPTH));
    assign push_fire      = ord_push_valid & ord_push_ready;
    assign retire         = streaming & rm_valid & m_ready & rm_last;

    // -----------------------------------------------------------------------
    // Datapath: zero-latency pass-through while streaming
    // -----------------------------------------------------------------------
    assign busy        = streaming;
    assign free_req    = streaming;
    // In IDLE the last drained UID is held so the response memory sees a
    // stable request index.
    assign uid_to_free = streaming ? head_uid : last_uid_reg;
    assign m_valid     = streaming & rm_valid;
    assign m_id        = head_orig;
    assign m_data      = rm_data;
    assign m_resp      = rm_resp;
    assign m_last      = rm_last;
    assign rm_ready    = streaming & rm_valid & m_ready;
    assign order_count = count_reg;

    // -----------------------------------------------------------------------
    // Queue storage (no reset: entries are qualified by the pointers)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_fire) begin
            uid_mem[wr_ptr_reg]  <= ord_push_uid;
            orig_mem[wr_ptr_reg] <= ord_push_orig_id;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers, count, FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            last_uid_reg <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (retire) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_fire, retire})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase

            if (streaming) begin
                last_uid_reg <= head_uid;
            end

            case (state_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        state_reg <= STREAM;
                    end
                end
                STREAM: begin
                    // Decision uses the registered count: a push landing in
                    // the same cycle as the last retire is picked up from
                    // IDLE on the following cycle.
                    if (retire && (count_reg <= CW'(1))) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Optional protocol checker
    // -----------------------------------------------------------------------
`ifdef R_ORDER_CHECK_EN
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (streaming &&
                     ((rm_valid && (rm_id != head_uid)) || (free_ack != rm_valid))) begin
            err_reg <= 1'b1;
        end
    end

    assign err_order = err_reg;
`else
    logic unused_chk;
    assign unused_chk = &{1'b0, free_ack, rm_id};
    assign err_order  = 1'b0;
`endif

endmodule

// File: tb/tb_r_order_release.sv
// ---------------------------------------------------------------------------
// tb_r_order_release
//
// Directed bench for r_order_release. The response memory is stood in for by
// driving rm_* directly with hand-picked beats for the requested UID.
// Inputs change 1 ns after the rising edge, and checks sample 1 ns later.
// ---------------------------------------------------------------------------
module tb_r_order_release;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ord_push_valid;
    logic [3:0]  ord_push_uid;
    logic [3:0]  ord_push_orig_id;
    logic        ord_push_ready;
    logic        free_req;
    logic [3:0]  uid_to_free;
    logic        free_ack;
    logic        rm_valid;
    logic [3:0]  rm_id;
    logic [63:0] rm_data;
    logic [1:0]  rm_resp;
    logic        rm_last;
    logic        rm_ready;
    logic        m_valid;
    logic [3:0]  m_id;
    logic [63:0] m_data;
    logic [1:0]  m_resp;
    logic        m_last;
    logic        m_ready;
    logic [4:0]  order_count;
    logic        busy;
    logic        err_order;

    int checks   = 0;
    int failures = 0;

`ifdef R_ORDER_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    r_order_release dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ord_push_valid   (ord_push_valid),
        .ord_push_uid     (ord_push_uid),
        .ord_push_orig_id (ord_push_orig_id),
        .ord_push_ready   (ord_push_ready),
        .free_req         (free_req),
        .uid_to_free      (uid_to_free),
        .free_ack         (free_ack),
        .rm_valid         (rm_valid),
        .rm_id            (rm_id),
        .rm_data          (rm_data),
        .rm_resp          (rm_resp),
        .rm_last          (rm_last),
        .rm_ready         (rm_ready),
        .m_valid          (m_valid),
        .m_id             (m_id),
        .m_data           (m_data),
        .m_resp           (m_resp),
        .m_last           (m_last),
        .m_ready          (m_ready),
        .order_count      (order_count),
        .busy             (busy),
        .err_order        (err_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat from the response memory (free_ack follows rm_valid).
    task automatic beat(input logic v, input logic [3:0] id, input logic [63:0] d,
                        input logic l, input logic rdy);
        rm_valid = v;
        free_ack = v;
        rm_id    = id;
        rm_data  = d;
        rm_resp  = 2'b00;
        rm_last  = l;
        m_ready  = rdy;
    endtask

    task automatic push(input logic [3:0] uid, input logic [3:0] orig);
        ord_push_valid   = 1'b1;
        ord_push_uid     = uid;
        ord_push_orig_id = orig;
    endtask

    initial begin
        rst_n = 1'b0;
        ord_push_valid = 1'b0;
        ord_push_uid = '0;
        ord_push_orig_id = '0;
        beat(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_free_req", free_req, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_rm_ready", rm_ready, 0);
        chk("rst_count", order_count, 0);
        chk("rst_err", err_order, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_push_ready", ord_push_ready, 1);
        $display("txn reset released");

        // ---------------- single 4-beat burst ----------------
        push(4'd3, 4'd5);
        tick();
        ord_push_valid = 1'b0;
        #1;
        chk("t1_count_after_push", order_count, 1);
        chk("t1_busy_idle", busy, 0);
        tick();
        chk("t1_busy", busy, 1);
        chk("t1_free_req", free_req, 1);
        chk("t1_uid_to_free", uid_to_free, 3);
        chk("t1_stall_no_valid", m_valid, 0);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 4'd3, 64'h100 + 64'(i), (i == 3), 1'b1);
            #1;
            chk("t1_m_valid", m_valid, 1);
            chk("t1_m_id", m_id, 5);
            chk("t1_m_data", m_data, 64'h100 + 64'(i));
            chk("t1_m_last", m_last, (i == 3));
            chk("t1_rm_ready", rm_ready, 1);
            $display("txn t1 beat %0d data=%0h last=%0b", i, m_data, m_last);
            tick();
        end
        beat(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        #1;
        chk("t1_count_end", order_count, 0);
        chk("t1_idle", busy, 0);
        chk("t1_free_req_idle", free_req, 0);
        chk("t1_uid_hold", uid_to_free, 3);

        // ---------------- in-order release ----------------
        // uid7's burst arrives upstream first but must wait behind uid2.
        tick();
        push(4'd2, 4'd1);
        tick();
        push(4'd7, 4'd6);
        tick();
        ord_push_valid = 1'b0;
        #1;
        chk("t2_count", order_count, 2);
        chk("t2_busy", busy, 1);
        chk("t2_head_uid2", uid_to_free, 2);
        beat(1'b1, 4'd2, 64'h200, 1'b1, 1'b1);
        #1;
        chk("t2_m_id_uid2", m_id, 1);
        chk("t2_m_data_uid2", m_data, 64'h200);
        $display("txn t2 uid2 beat data=%0h id=%0h", m_data, m_id);
        tick();
        // next head served immediately, no bubble
        beat(1'b1, 4'd7, 64'h700, 1'b0, 1'b1);
        #1;
        chk("t2_busy_nobubble", busy, 1);
        chk("t2_head_uid7", uid_to_free, 7);
        chk("t2_m_valid_uid7", m_valid, 1);
        chk("t2_m_id_uid7", m_id, 6);
        chk("t2_count_mid", order_count, 1);
        $display("txn t2 uid7 beat0 data=%0h id=%0h", m_data, m_id);
        tick();
        beat(1'b1, 4'd7, 64'h701, 1'b1, 1'b1);
        #1;
        chk("t2_m_data_uid7b", m_data, 64'h701);
        chk("t2_m_last_uid7b", m_last, 1);
        $display("txn t2 uid7 beat1 data=%0h id=%0h", m_data, m_id);
        tick();
        beat(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        #1;
        chk("t2_count_end", order_count, 0);
        chk("t2_idle", busy, 0);

        // ---------------- m_ready backpressure ----------------
        push(4'd4, 4'd2);
        tick();
        ord_push_valid = 1'b0;
        tick();
        beat(1'b1, 4'd4, 64'hA1, 1'b0, 1'b1);
        #1;
        chk("t3_a_rm_ready", rm_ready, 1);
        $display("txn t3 beat A data=%0h", m_data);
        tick();
        beat(1'b1, 4'd4, 64'hB2, 1'b0, 1'b0);
        #1;
        chk("t3_stall1_valid", m_valid, 1);
        chk("t3_stall1_rm_ready", rm_ready, 0);
        chk("t3_stall1_data", m_data, 64'hB2);
        tick();
        #1;
        chk("t3_stall2_rm_ready", rm_ready, 0);
        chk("t3_stall2_data", m_data, 64'hB2);
        tick();
        m_ready = 1'b1;
        #1;
        chk("t3_b_rm_ready", rm_ready, 1);
        chk("t3_b_data", m_data, 64'hB2);
        $display("txn t3 beat B data=%0h", m_data);
        tick();
        beat(1'b1, 4'd4, 64'hC3, 1'b1, 1'b1);
        #1;
        chk("t3_c_data", m_data, 64'hC3);
        chk("t3_c_count", order_count, 1);
        $display("txn t3 beat C data=%0h", m_data);
        tick();
        beat(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        #1;
        chk("t3_count_end", order_count, 0);

        // ---------------- protocol checker ----------------
        push(4'd4, 4'd3);
        tick();
        ord_push_valid = 1'b0;
        tick();
        beat(1'b1, 4'd9, 64'hEE, 1'b0, 1'b0);
        tick();
        beat(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        #1;
        chk("t4_err_set", err_order, ERR_EXP);
        tick();
        chk("t4_err_sticky", err_order, ERR_EXP);
        $display("txn t4 bad rm_id injected err=%0b", err_order);
        beat(1'b1, 4'd4, 64'h44, 1'b1, 1'b1);
        tick();
        beat(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        #1;
        chk("t4_count_end", order_count, 0);
        chk("t4_err_still", err_order, ERR_EXP);

        // ---------------- full queue ----------------
        for (int i = 0; i < 16; i++) begin
            push(4'(i), 4'(15 - i));
            tick();
        end
        // 17th push held
        push(4'd1, 4'd1);
        #1;
        chk("t5_full_count", order_count, 16);
        chk("t5_full_ready", ord_push_ready, 0);
        tick();
        chk("t5_held_count", order_count, 16);
        $display("txn t5 queue full count=%0d", order_count);
        // Retire head (uid0) with a push in the same cycle: the push is
        // refused because ready is low, the pop still happens -> 15.
        chk("t5_head_uid0", uid_to_free, 0);
        chk("t5_head_orig", m_id, 15);
        beat(1'b1, 4'd0, 64'h500, 1'b1, 1'b1);
        tick();
        ord_push_valid = 1'b0;
        beat(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        #1;
        chk("t5_retire_push_count", order_count, 15);
        chk("t5_ready_after", ord_push_ready, 1);
        chk("t5_next_head", uid_to_free, 1);
        chk("t5_next_orig", m_id, 14);

        // ---------------- reset mid-burst ----------------
        tick();
        beat(1'b1, 4'd1, 64'h600, 1'b0, 1'b1);
        tick();
        beat(1'b1, 4'd1, 64'h601, 1'b0, 1'b1);
        #1;
        chk("t6_beat2_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_m_valid", m_valid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_free_req", free_req, 0);
        chk("t6_async_rm_ready", rm_ready, 0);
        chk("t6_async_count", order_count, 0);
        chk("t6_async_err", err_order, 0);
        beat(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_ready_after", ord_push_ready, 1);
        chk("t6_count_after", order_count, 0);
        chk("t6_busy_after", busy, 0);
        $display("txn t6 reset mid-burst recovered");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
